avalon_mem_responder: RTL and testbench

//   Avalon-MM responder (memory slave) for the load/store path: word-organised RAM with byte-lane writes
//   and programmable waitrequest stalls. Serves the CPU's data/instruction master in simulation and on the

---
 rtl/avalon_mem_responder_pkg.sv | 16 +
 rtl/avalon_mem_responder_if.sv | 24 ++
 rtl/avalon_mem_responder_lfsr.sv | 26 ++
 rtl/avalon_mem_responder.sv | 119 +++++++++++
 tb/tb_avalon_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/avalon_mem_responder_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
// Optional random-wait build: AVALON_MEM_RESPONDER_RANDOM_WAIT_EN.
package avalon_mem_pkg;

    typedef enum logic {
        StIdle,
        StStall
    } state_e;

    localparam int unsigned AVALON_DATA_W = 32;
    localparam int unsigned AVALON_BE_W   = 4;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM request/response bundle between a master and the memory responder.
interface avalon_mem_responder_if;
    import avalon_mem_pkg::*;

    logic [31:0]              address;
    logic                     read;
    logic                     write;
    logic [AVALON_DATA_W-1:0] writedata;
    logic [AVALON_BE_W-1:0]   byteenable;
    logic                     waitrequest;
    logic [AVALON_DATA_W-1:0] readdata;
    logic                     err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, err
    );

endinterface

// File: rtl/avalon_mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR that advances one step per accepted transfer.
module avalon_lfsr16
    import avalon_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= seed_i;
        else          lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM word RAM responder with byte-lane writes and programmable waitrequest stalls.
// Define AVALON_MEM_RESPONDER_RANDOM_WAIT_EN for LFSR-driven stall lengths.
module avalon_mem_responder
    import avalon_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = "",
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                   clk,
    input logic                   reset_n,
    avalon_mem_responder_if.slave bus
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [AVALON_DATA_W-1:0] mem [Depth];

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d, wait_now;
    logic [AVALON_DATA_W-1:0] rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     req, waitreq, accept, bad, in_range, mem_we;
    logic [31:0]              offset;
    logic [DEPTH_LOG2-1:0]    idx;

`ifdef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    avalon_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed_i  (LFSR_SEED),
        .step_i  (accept),
        .value_o (lfsr)
    );

    // The LFSR only moves on acceptance, so this stays stable for a whole stall.
    assign wait_now = CntW'(lfsr % 16'(WAIT_CYCLES + 1));
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign wait_now    = CntW'(WAIT_CYCLES);
`endif

    // Unsigned subtraction; an underflow is caught by the lower-bound compare.
    assign offset   = bus.address - BASE_ADDR;
    assign in_range = (bus.address >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign idx      = offset[DEPTH_LOG2+1:2];
    assign bad      = !in_range || (bus.address[1:0] != 2'b00) || (bus.read && bus.write);

    assign req     = bus.read || bus.write;
    assign waitreq = req && (wait_now != '0) && !(state_q == StStall && cnt_q == '0);
    assign accept  = req && !waitreq;
    assign mem_we  = accept && bus.write && !bad && reset_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req && (wait_now != '0)) begin
                    state_d = StStall;
                    cnt_d   = wait_now - 1'b1;
                end
            end
            StStall: begin
                if (!req) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        if (accept) begin
            if (bad) begin
                err_d = 1'b1;
                if (bus.read) rdata_d = '0;
            end else if (bus.read) begin
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < AVALON_BE_W; i++) begin
                if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    assign bus.waitrequest = waitreq;
    assign bus.readdata    = rdata_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: three instances with WAIT_CYCLES 0, 1 and 3.
module tb_avalon_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [3:0]  be = '0;
    int          sel = 1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    avalon_mem_responder_if bus0 ();
    avalon_mem_responder_if bus1 ();
    avalon_mem_responder_if bus3 ();

    assign bus0.address = addr; assign bus0.writedata = wdata; assign bus0.byteenable = be;
    assign bus1.address = addr; assign bus1.writedata = wdata; assign bus1.byteenable = be;
    assign bus3.address = addr; assign bus3.writedata = wdata; assign bus3.byteenable = be;
    assign bus0.read = rd && (sel == 0); assign bus0.write = wr && (sel == 0);
    assign bus1.read = rd && (sel == 1); assign bus1.write = wr && (sel == 1);
    assign bus3.read = rd && (sel == 3); assign bus3.write = wr && (sel == 3);

    avalon_mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    avalon_mem_responder #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    avalon_mem_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    logic        wreq, err;
    logic [31:0] rdata;

    always_comb begin
        wreq  = bus1.waitrequest;
        err   = bus1.err;
        rdata = bus1.readdata;
        if (sel == 0) begin
            wreq = bus0.waitrequest; err = bus0.err; rdata = bus0.readdata;
        end else if (sel == 3) begin
            wreq = bus3.waitrequest; err = bus3.err; rdata = bus3.readdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_stalls(input string tag, input int obs, input int exp);
`ifdef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
        check(tag, 32'(obs <= exp), 32'd1);
`else
        check(tag, 32'(obs), 32'(exp));
`endif
    endtask

    // Holds the request until accepted; returns with #1 after the accepting edge.
    task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int stalls);
        bit done = 1'b0;
        addr = a; rd = r; wr = w; wdata = d; be = b; stalls = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (wreq) stalls++;
            else      done = 1'b1;
            @(posedge clk); #1;
        end
        check("accept_within_bound", 32'(done), 32'd1);
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0; reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    int st;
`ifdef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
    int seq [300];
    bit seen [4];
`endif

    initial begin
        do_reset();
        sel = 1;
        @(negedge clk);
        check("rst_waitrequest", 32'(wreq), 32'd0);
        check("rst_readdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // WAIT=1 store then load
        xfer(0, 1, 32'hBFC0_0004, 32'hDEAD_BEEF, 4'hF, st);
        chk_stalls("w1_sw_stalls", st, 1);
        xfer(1, 0, 32'hBFC0_0004, 32'h0, 4'hF, st);
        chk_stalls("w1_lw_stalls", st, 1);
        check("w1_lw_data", rdata, 32'hDEAD_BEEF);
        idle();

        // Byte lanes
        xfer(0, 1, 32'hBFC0_0008, 32'h1122_3344, 4'hF, st);
        xfer(0, 1, 32'hBFC0_0008, 32'hAABB_CCDD, 4'b0101, st);
        xfer(0, 1, 32'hBFC0_0008, 32'hFFFF_FFFF, 4'b0000, st);
        xfer(1, 0, 32'hBFC0_0008, 32'h0, 4'h0, st);
        check("lane_merge", rdata, 32'h11BB_33DD);
        check("lane_no_err", 32'(err), 32'd0);
        idle();

        // WAIT=0 back-to-back
        sel = 0;
        xfer(0, 1, 32'hBFC0_0000, 32'hCAFE_F00D, 4'hF, st);
        chk_stalls("w0_write_stalls", st, 0);
        xfer(0, 1, 32'hBFC0_0004, 32'h1234_5678, 4'hF, st);
        xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'hF, st);
        chk_stalls("w0_rd0_stalls", st, 0);
        check("w0_rd0_data", rdata, 32'hCAFE_F00D);
        xfer(1, 0, 32'hBFC0_0004, 32'h0, 4'hF, st);
        chk_stalls("w0_rd1_stalls", st, 0);
        check("w0_rd1_data", rdata, 32'h1234_5678);
        idle();

        // WAIT=3 full stall, then abandoned request
        sel = 3;
        xfer(0, 1, 32'hBFC0_0010, 32'h5A5A_5A5A, 4'hF, st);
        chk_stalls("w3_write_stalls", st, 3);
        xfer(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, st);
        chk_stalls("w3_read_stalls", st, 3);
        check("w3_read_data", rdata, 32'h5A5A_5A5A);
        idle();
        check("w3_err_before_drop", 32'(err), 32'd0);
`ifndef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
        addr = 32'hBFC0_0010; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #1;
        check("w3_drop_err", 32'(err), 32'd1);
`endif

        // Address errors on WAIT=1
        sel = 1;
        xfer(0, 1, 32'hBFC0_0000, 32'h0102_0304, 4'hF, st);
        check("oor_err_clear", 32'(err), 32'd0);
        xfer(0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, st);
        check("oor_low_err", 32'(err), 32'd1);
        xfer(0, 1, 32'hBFC0_1000, 32'hFFFF_FFFF, 4'hF, st);
        xfer(1, 0, 32'hBFC0_0002, 32'h0, 4'hF, st);
        check("misaligned_rdata", rdata, 32'h0);
        xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'hF, st);
        check("oor_word0_intact", rdata, 32'h0102_0304);
        xfer(1, 1, 32'hBFC0_0000, 32'h0, 4'hF, st);
        check("rdwr_rdata", rdata, 32'h0);
        xfer(1, 0, 32'hBFC0_0000, 32'h0, 4'hF, st);
        check("rdwr_word0_intact", rdata, 32'h0102_0304);
        idle();
        idle();
        check("err_sticky", 32'(err), 32'd1);
        do_reset();
        check("err_reset", 32'(err), 32'd0);
        sel = 3;
        check("w3_err_reset", 32'(err), 32'd0);
        check("w3_rdata_reset", rdata, 32'h0);

`ifndef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
        // Reset while a write is stalled
        addr = 32'hBFC0_0010; wr = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        check("rst_stall_waitreq", 32'(wreq), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        xfer(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, st);
        check("rst_stall_word_intact", rdata, 32'h5A5A_5A5A);
        check("rst_stall_read_stalls", 32'(st), 32'd3);
        idle();
`else
        // Random stall lengths on WAIT=3, repeatable from reset
        do_reset();
        for (int i = 0; i < 300; i++) begin
            xfer(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, st);
            seq[i] = st;
            check("rand_range", 32'(st <= 3), 32'd1);
            if (st <= 3) seen[st] = 1'b1;
        end
        for (int v = 0; v < 4; v++) check("rand_value_seen", 32'(seen[v]), 32'd1);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            xfer(1, 0, 32'hBFC0_0010, 32'h0, 4'hF, st);
            check("rand_repeat", 32'(st), 32'(seq[i]));
        end
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
